// File: rtl/syn_pipeline_if_id_pkg.sv
// Shared constants and the per-edge update decision for the IF/ID pipeline register.
package syn_pipeline_if_id_pkg;

  localparam int          IM_ADDR_BIT = 10;
  localparam int          PERF_W      = 32;
  localparam logic [31:0] INST_NOP    = 32'h0000_0000;

  typedef enum logic [1:0] {
    ACT_HOLD  = 2'd0,
    ACT_FLUSH = 2'd1,
    ACT_LOAD  = 2'd2
  } if_id_act_e;

  // Disabled step beats flush, flush beats the halt freeze, the freeze beats stall.
  function automatic if_id_act_e sel_action(
    input logic en,
    input logic flush,
    input logic halted,
    input logic stall
  );
    if (!en)
      return ACT_HOLD;
    else if (flush)
      return ACT_FLUSH;
    else if (halted || stall)
      return ACT_HOLD;
    else
      return ACT_LOAD;
  endfunction

endpackage

// File: rtl/syn_perf_counter.sv
// Enable-gated wrapping event counter with synchronous active-low reset.
module syn_perf_counter
  import syn_pipeline_if_id_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  output logic [PERF_W-1:0] count
);

  logic [PERF_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_count <= '0;
    else if (inc)
      r_count <= r_count + PERF_W'(1);
  end

  assign count = r_count;

endmodule

// File: rtl/syn_pipeline_if_id.sv
// IF/ID pipeline register with stall hold, flush bubble, sticky halt and PC hold request.
// Optional event counters are built only when PIPE_PERF_EN is defined.
module syn_pipeline_if_id
  import syn_pipeline_if_id_pkg::*;
#(
  parameter int ADDR_W = IM_ADDR_BIT,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              stall,
  input  logic              flush,
  input  logic              halt,
  input  logic [ADDR_W-1:0] pc_4,
  input  logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] pc_4_if_id,
  output logic [INST_W-1:0] inst_if_id,
  output logic              valid_if_id,
  output logic              halted_if,
  output logic              pc_hold,
  output logic [31:0]       perf_inst,
  output logic [31:0]       perf_stall,
  output logic [31:0]       perf_flush
);

  logic [ADDR_W-1:0] r_pc_4;
  logic [INST_W-1:0] r_inst;
  logic              r_valid;
  logic              r_halted;
  if_id_act_e        w_act;

  assign w_act = sel_action(en, flush, r_halted, stall);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc_4  <= '0;
      r_inst  <= INST_W'(INST_NOP);
      r_valid <= 1'b0;
    end else begin
      case (w_act)
        ACT_LOAD: begin
          r_pc_4  <= pc_4;
          r_inst  <= inst;
          r_valid <= 1'b1;
        end
        ACT_FLUSH: begin
          r_pc_4  <= '0;
          r_inst  <= INST_W'(INST_NOP);
          r_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Halt takes effect from the edge after it is seen, so a same-edge load still lands.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_halted <= 1'b0;
    else if (en && halt)
      r_halted <= 1'b1;
  end

  // A flush redirect must reach the PC even while ID is asking for a stall.
  assign pc_hold     = r_halted | (stall & ~flush);
  assign pc_4_if_id  = r_pc_4;
  assign inst_if_id  = r_inst;
  assign valid_if_id = r_valid;
  assign halted_if   = r_halted;

`ifdef PIPE_PERF_EN
  logic w_inc_inst;
  logic w_inc_stall;
  logic w_inc_flush;

  assign w_inc_inst  = (w_act == ACT_LOAD);
  assign w_inc_stall = en & stall & ~flush;
  assign w_inc_flush = en & flush;

  syn_perf_counter u_perf_inst (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_inc_inst),
    .count (perf_inst)
  );

  syn_perf_counter u_perf_stall (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_inc_stall),
    .count (perf_stall)
  );

  syn_perf_counter u_perf_flush (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_inc_flush),
    .count (perf_flush)
  );
`else
  assign perf_inst  = 32'd0;
  assign perf_stall = 32'd0;
  assign perf_flush = 32'd0;
`endif

endmodule

// File: tb/tb_syn_pipeline_if_id.sv
// Scoreboard bench for syn_pipeline_if_id: directed sequence then randomized traffic.
module tb_syn_pipeline_if_id;

  localparam int AW = 10;
  localparam int IW = 32;
`ifdef PIPE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, en, stall, flush, halt;
  logic [AW-1:0] pc_4;
  logic [IW-1:0] inst;
  logic [AW-1:0] pc_4_if_id;
  logic [IW-1:0] inst_if_id;
  logic          valid_if_id, halted_if, pc_hold;
  logic [31:0]   perf_inst, perf_stall, perf_flush;

  int errors = 0;
  int checks = 0;
  bit done   = 1'b0;

  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] inst;
    logic          valid;
    logic          halted;
    logic [31:0]   p_inst;
    logic [31:0]   p_stall;
    logic [31:0]   p_flush;
  } exp_t;

  exp_t exp_q[$];

  // Reference state: what ID should currently be holding.
  logic [AW-1:0] m_pc;
  logic [IW-1:0] m_inst;
  logic          m_valid, m_halted;
  logic [31:0]   m_pi, m_ps, m_pf;

  always #5 clk = ~clk;

  syn_pipeline_if_id #(.ADDR_W(AW), .INST_W(IW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .stall       (stall),
    .flush       (flush),
    .halt        (halt),
    .pc_4        (pc_4),
    .inst        (inst),
    .pc_4_if_id  (pc_4_if_id),
    .inst_if_id  (inst_if_id),
    .valid_if_id (valid_if_id),
    .halted_if   (halted_if),
    .pc_hold     (pc_hold),
    .perf_inst   (perf_inst),
    .perf_stall  (perf_stall),
    .perf_flush  (perf_flush)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Model: apply the register's rules to the inputs seen at this edge, queue the outcome.
  initial begin
    forever begin
      exp_t e;
      @(posedge clk);
      if (!rst_n) begin
        m_pc = '0; m_inst = '0; m_valid = 1'b0; m_halted = 1'b0;
        m_pi = 0; m_ps = 0; m_pf = 0;
      end else if (en) begin
        if (flush) begin
          m_pc = '0; m_inst = '0; m_valid = 1'b0;
          m_pf = m_pf + 1;
        end else begin
          if (stall) m_ps = m_ps + 1;
          if (!m_halted && !stall) begin
            m_pc = pc_4; m_inst = inst; m_valid = 1'b1;
            m_pi = m_pi + 1;
          end
        end
        if (halt) m_halted = 1'b1;
      end
      e.pc = m_pc; e.inst = m_inst; e.valid = m_valid; e.halted = m_halted;
      e.p_inst  = PERF ? m_pi : 32'd0;
      e.p_stall = PERF ? m_ps : 32'd0;
      e.p_flush = PERF ? m_pf : 32'd0;
      exp_q.push_back(e);
    end
  end

  // Monitor: the register presents new contents after every edge.
  initial begin
    forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        errors++; checks++;
        $display("FAIL scoreboard_empty: got 0 entries expected 1");
      end else begin
        e = exp_q.pop_front();
        check32("pc_4_if_id", 32'(pc_4_if_id), 32'(e.pc));
        check32("inst_if_id", inst_if_id, e.inst);
        check32("valid_if_id", 32'(valid_if_id), 32'(e.valid));
        check32("halted_if", 32'(halted_if), 32'(e.halted));
        check32("perf_inst", perf_inst, e.p_inst);
        check32("perf_stall", perf_stall, e.p_stall);
        check32("perf_flush", perf_flush, e.p_flush);
        if (!done)
          $display("t=%0t pc=%h inst=%h v=%0b h=%0b", $time, pc_4_if_id, inst_if_id,
                   valid_if_id, halted_if);
      end
    end
  end

  // Drive one cycle of inputs at the falling edge and check the combinational hold request.
  task automatic drive(input logic r, input logic e, input logic s, input logic f,
                       input logic h, input logic [AW-1:0] p, input logic [IW-1:0] i);
    @(negedge clk);
    rst_n = r; en = e; stall = s; flush = f; halt = h; pc_4 = p; inst = i;
    #1;
    if (m_halted !== 1'bx)
      check32("pc_hold", 32'(pc_hold), 32'(m_halted | (s & ~f)));
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; stall = 1'b0; flush = 1'b0; halt = 1'b0;
    pc_4 = '0; inst = 32'h2008_0005;
    m_halted = 1'bx;
    drive(0, 1, 0, 0, 0, 10'h000, 32'h2008_0005);
    drive(0, 1, 0, 0, 0, 10'h000, 32'h2008_0005);
    drive(1, 1, 0, 0, 0, 10'h004, 32'h2008_0005);
    drive(1, 1, 1, 0, 0, 10'h005, 32'h8C09_0000);
    drive(1, 1, 1, 0, 0, 10'h005, 32'h8C09_0000);
    drive(1, 1, 1, 1, 0, 10'h006, 32'h1111_2222);
    drive(1, 1, 0, 0, 0, 10'h010, 32'hAAAA_5555);
    drive(1, 0, 0, 1, 0, 10'h011, 32'h3333_4444);
    drive(1, 1, 0, 0, 1, 10'h012, 32'h5555_6666);
    drive(1, 1, 0, 0, 0, 10'h013, 32'h7777_8888);
    drive(1, 1, 0, 1, 0, 10'h014, 32'h9999_AAAA);
    drive(1, 1, 0, 0, 0, 10'h015, 32'hBBBB_CCCC);
    drive(0, 0, 1, 0, 0, 10'h016, 32'hDDDD_EEEE);
    drive(1, 1, 0, 0, 0, 10'h017, 32'h0F0F_0F0F);
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 39) != 0),
            ($urandom_range(0, 7) != 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 49) == 0),
            AW'($urandom), IW'($urandom));
    end
    drive(1, 0, 0, 0, 0, '0, '0);
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/syn_pipeline_if_id.md
Name: syn_pipeline_if_id

Overview:
IF/ID pipeline register between the fetch stage (PC + instruction memory) and the decode stage (decoder, control, register file).
- Latches pc_4 and the fetched instruction each enabled cycle.
- Supports load-use stall (hold), branch/jump flush (bubble) and sticky halt freeze.
- Generates the PC hold request for the PC register.

Parameters:
ADDR_W, `IM_ADDR_BIT, word-address width of pc_4.
INST_W, 32, instruction width.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  synchronous active-low reset; sampled on rising edge of clk.
en  input  1  global step enable; when 0, all state holds.
stall  input  1  load-use stall from hazard detection in ID.
flush  input  1  redirect from EX (jumped || branched).
halt  input  1  halt indication from DM/WB.
pc_4  input  ADDR_W  fetch-stage PC+1 (word address).
inst  input  INST_W  instruction from instruction memory.
pc_4_if_id  output  ADDR_W  registered pc_4.
inst_if_id  output  INST_W  registered instruction.
valid_if_id  output  1  1 = inst_if_id is a real instruction; 0 = bubble.
halted_if  output  1  sticky halt state.
pc_hold  output  1  combinational: freeze PC this cycle.
perf_inst  output  32  instructions delivered to ID (feature-dependent).
perf_stall  output  32  stall cycles (feature-dependent).
perf_flush  output  32  flush cycles (feature-dependent).

Behaviour:
- Reset (rst_n=0 at posedge, regardless of en): pc_4_if_id=0, inst_if_id=`INST_NOP (32'h0), valid_if_id=0, halted_if=0, perf counters=0.
- Update priority at posedge with rst_n=1: en=0 > flush > halted_if > stall > load.
- en=0: every register holds, including counters.
- flush=1: inst_if_id=`INST_NOP, pc_4_if_id=0, valid_if_id=0. Overrides a simultaneous stall.
- halted_if=1 (not flushing): hold all outputs.
- stall=1: hold all outputs.
- Otherwise (load): pc_4_if_id<=pc_4, inst_if_id<=inst, valid_if_id<=1. Latency is 1 cycle.
- Halt state:
  - halted_if<=1 on any enabled posedge with halt=1.
  - Clears only on reset.
  - flush while halted still inserts a bubble.
- pc_hold = halted_if | (stall & ~flush). Purely combinational, independent of en.
  - Stall+flush in the same cycle lets the PC load the redirect target.
- A simultaneous halt and load on the same edge still loads; the freeze applies from the next edge.
- Reset in the middle of a stall or halt returns to the reset state in one edge.

Optional Feature:
PIPE_PERF_EN
- Defined:
  - perf_inst increments on each load edge.
  - perf_stall increments on edges where stall & ~flush & en.
  - perf_flush increments on edges where flush & en.
  - All counters are 32-bit, wrap 0xFFFFFFFF->0, and count only when en=1.
- Undefined: perf_* tied to 32'd0, no counter flops.

Decomposition:
- Core.vh: `IM_ADDR_BIT, `INST_NOP (32'h0000_0000).
- One sub-module, syn_perf_counter: enable-gated 32-bit wrapping counter with synchronous active-low reset. Instantiated three times under PIPE_PERF_EN.

Test Plan:
- Reset: rst_n=0 for 2 cycles with en=1, inst=32'h2008_0005 -> outputs 0, valid 0, pc_hold 0.
- Load: pc_4=10'h004, inst=32'h2008_0005, en=1 -> next cycle pc_4_if_id=4, inst_if_id=32'h2008_0005, valid=1.
- Stall: stall=1 for 2 cycles while inst changes to 32'h8C09_0000 -> outputs hold 32'h2008_0005, pc_hold=1; perf_stall=2 with PIPE_PERF_EN.
- Stall+flush: stall=1, flush=1 -> pc_hold=0; next cycle inst_if_id=0, valid=0; perf_flush=1, perf_stall unchanged.
- en gating: en=0 with flush=1 -> no change. Then halt=1 with en=1 -> halted_if=1, pc_hold=1, later inst changes ignored; rst_n=0 clears.
- Wrap: preload perf_inst near 32'hFFFF_FFFF via a long run (or force) -> next load gives 0.
